// File: rtl/regfile_scoreboard_if.sv
// Issue and write-port bundle between Decode/Writeback and the register file
// scoreboard.
//   master : Decode/Writeback side. It drives the issue fields and the write
//            port, and it observes the accept, stall and operand outputs.
//   slave  : regfile_scoreboard side, which is the mirror image of master.
interface regfile_scoreboard_if #(
  parameter int REG_WIDTH = 16,
  parameter int IDX_WIDTH = 4
);
  logic                 I_IssueValid;
  logic [IDX_WIDTH-1:0] I_Src1Idx;
  logic                 I_Src1Used;
  logic [IDX_WIDTH-1:0] I_Src2Idx;
  logic                 I_Src2Used;
  logic [IDX_WIDTH-1:0] I_DestIdx;
  logic                 I_DestWrite;
  logic                 I_IsBranch;
  logic                 I_BranchResolved;
  logic                 I_WriteBackEnable;
  logic [IDX_WIDTH-1:0] I_WriteBackRegIdx;
  logic [REG_WIDTH-1:0] I_WriteBackData;
  logic                 O_Accept;
  logic                 O_DepStallSignal;
  logic                 O_BranchStallSignal;
  logic                 O_OutValid;
  logic [REG_WIDTH-1:0] O_Src1Value;
  logic [REG_WIDTH-1:0] O_Src2Value;
  logic                 O_ScoreboardError;

  modport master (
    output I_IssueValid, I_Src1Idx, I_Src1Used, I_Src2Idx, I_Src2Used,
           I_DestIdx, I_DestWrite, I_IsBranch, I_BranchResolved,
           I_WriteBackEnable, I_WriteBackRegIdx, I_WriteBackData,
    input  O_Accept, O_DepStallSignal, O_BranchStallSignal, O_OutValid,
           O_Src1Value, O_Src2Value, O_ScoreboardError
  );

  modport slave (
    input  I_IssueValid, I_Src1Idx, I_Src1Used, I_Src2Idx, I_Src2Used,
           I_DestIdx, I_DestWrite, I_IsBranch, I_BranchResolved,
           I_WriteBackEnable, I_WriteBackRegIdx, I_WriteBackData,
    output O_Accept, O_DepStallSignal, O_BranchStallSignal, O_OutValid,
           O_Src1Value, O_Src2Value, O_ScoreboardError
  );
endinterface

// File: rtl/regfile_scoreboard.sv
// Decode-side architectural register file with a per-register scoreboard of
// pending writes.
//   I_CLOCK : clock. All state changes on the rising edge.
//   I_LOCK  : synchronous active-low reset.
//   bus     : slave modport.
//             Issue inputs: src1/src2/dest, branch, and branch-resolved.
//             Write port:   the writeback enable, index and data.
//             Outputs:      accept and dependency stall (combinational);
//                           branch stall, operand valid and the two operand
//                           values (registered); and a sticky protocol-error
//                           flag.
module regfile_scoreboard #(
  parameter int REG_WIDTH = 16,
  parameter int NUM_REGS  = 16,
  parameter int IDX_WIDTH = 4,
  parameter int CNT_WIDTH = 2
) (
  input logic            I_CLOCK,
  input logic            I_LOCK,
  regfile_scoreboard_if.slave bus
);

  localparam logic [CNT_WIDTH-1:0] CNT_MAX = '1;
  localparam logic [CNT_WIDTH-1:0] CNT_ONE = CNT_WIDTH'(1);

  logic [REG_WIDTH-1:0] regs [NUM_REGS];
  logic [CNT_WIDTH-1:0] cnt  [NUM_REGS];
  logic                 branch_pending;
  logic                 out_valid;
  logic [REG_WIDTH-1:0] src1_value;
  logic [REG_WIDTH-1:0] src2_value;
  logic                 sb_error;

  logic                 bypass1, bypass2;
  logic                 hazard1, hazard2, dest_full;
  logic                 dep_stall, accept;
  logic                 wb_hits_src1, wb_hits_src2;
  logic [NUM_REGS-1:0]  inc_vec, dec_vec;

  // The stall terms look only at indices, enables and counters. The
  // writeback data never feeds the stall path.
  assign wb_hits_src1 = bus.I_WriteBackEnable && (bus.I_WriteBackRegIdx == bus.I_Src1Idx);
  assign wb_hits_src2 = bus.I_WriteBackEnable && (bus.I_WriteBackRegIdx == bus.I_Src2Idx);

  // A same-cycle writeback can only be bypassed when it retires the last
  // pending write. With older writes still in flight, the value it carries
  // is not the newest one.
  assign bypass1 = wb_hits_src1 && (cnt[bus.I_Src1Idx] == CNT_ONE);
  assign bypass2 = wb_hits_src2 && (cnt[bus.I_Src2Idx] == CNT_ONE);
  assign hazard1 = bus.I_Src1Used && (cnt[bus.I_Src1Idx] != '0) && !bypass1;
  assign hazard2 = bus.I_Src2Used && (cnt[bus.I_Src2Idx] != '0) && !bypass2;
  assign dest_full = bus.I_DestWrite && (cnt[bus.I_DestIdx] == CNT_MAX) &&
                     !(bus.I_WriteBackEnable && (bus.I_WriteBackRegIdx == bus.I_DestIdx));

  assign dep_stall = bus.I_IssueValid && (hazard1 || hazard2 || dest_full);
  assign accept    = bus.I_IssueValid && !dep_stall && !branch_pending;

  always_comb begin
    inc_vec = '0;
    dec_vec = '0;
    if (accept && bus.I_DestWrite) inc_vec[bus.I_DestIdx] = 1'b1;
    if (bus.I_WriteBackEnable)     dec_vec[bus.I_WriteBackRegIdx] = 1'b1;
  end

  // Register file, scoreboard and operand stage. Results are one cycle after
  // accept.
  always_ff @(posedge I_CLOCK) begin
    if (!I_LOCK) begin
      for (int i = 0; i < NUM_REGS; i++) begin
        regs[i] <= '0;
        cnt[i]  <= '0;
      end
      branch_pending <= 1'b0;
      out_valid      <= 1'b0;
      src1_value     <= '0;
      src2_value     <= '0;
      sb_error       <= 1'b0;
    end else begin
      if (bus.I_WriteBackEnable) regs[bus.I_WriteBackRegIdx] <= bus.I_WriteBackData;

      // An increment and a decrement in the same cycle cancel out. A
      // decrement at zero is clamped, and it raises the error flag below.
      for (int i = 0; i < NUM_REGS; i++) begin
        if (inc_vec[i] && !dec_vec[i])
          cnt[i] <= cnt[i] + CNT_ONE;
        else if (dec_vec[i] && !inc_vec[i] && (cnt[i] != '0))
          cnt[i] <= cnt[i] - CNT_ONE;
      end

      if (bus.I_WriteBackEnable && (cnt[bus.I_WriteBackRegIdx] == '0))
        sb_error <= 1'b1;

      if (accept && bus.I_IsBranch)
        branch_pending <= 1'b1;
      else if (bus.I_BranchResolved)
        branch_pending <= 1'b0;

      out_valid <= accept;
      if (accept) begin
        src1_value <= wb_hits_src1 ? bus.I_WriteBackData : regs[bus.I_Src1Idx];
        src2_value <= wb_hits_src2 ? bus.I_WriteBackData : regs[bus.I_Src2Idx];
      end
    end
  end

  assign bus.O_Accept            = accept;
  assign bus.O_DepStallSignal    = dep_stall;
  assign bus.O_BranchStallSignal = branch_pending;
  assign bus.O_OutValid          = out_valid;
  assign bus.O_Src1Value         = src1_value;
  assign bus.O_Src2Value         = src2_value;
  assign bus.O_ScoreboardError   = sb_error;

endmodule

// File: tb/tb_regfile_scoreboard.sv
// Directed bench for regfile_scoreboard. Inputs change 1 ns after the rising
// edge. Combinational outputs are sampled 1 ns later, and registered outputs
// are sampled after the next edge.
module tb_regfile_scoreboard;
  logic I_CLOCK = 1'b0;
  logic I_LOCK  = 1'b0;
  int   errors  = 0;
  int   checks  = 0;

  regfile_scoreboard_if #(.REG_WIDTH(16), .IDX_WIDTH(4)) bus ();

  regfile_scoreboard #(
    .REG_WIDTH(16), .NUM_REGS(16), .IDX_WIDTH(4), .CNT_WIDTH(2)
  ) dut (
    .I_CLOCK(I_CLOCK),
    .I_LOCK (I_LOCK),
    .bus    (bus.slave)
  );

  always #5 I_CLOCK = ~I_CLOCK;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic idle();
    bus.I_IssueValid      = 1'b0;
    bus.I_Src1Idx         = '0;
    bus.I_Src1Used        = 1'b0;
    bus.I_Src2Idx         = '0;
    bus.I_Src2Used        = 1'b0;
    bus.I_DestIdx         = '0;
    bus.I_DestWrite       = 1'b0;
    bus.I_IsBranch        = 1'b0;
    bus.I_BranchResolved  = 1'b0;
    bus.I_WriteBackEnable = 1'b0;
    bus.I_WriteBackRegIdx = '0;
    bus.I_WriteBackData   = '0;
  endtask

  task automatic step();
    @(posedge I_CLOCK);
    #1;
  endtask

  task automatic issue(input logic [3:0] s1, input logic u1, input logic [3:0] s2,
                       input logic u2, input logic [3:0] d, input logic dw, input logic br);
    bus.I_IssueValid = 1'b1;
    bus.I_Src1Idx    = s1;
    bus.I_Src1Used   = u1;
    bus.I_Src2Idx    = s2;
    bus.I_Src2Used   = u2;
    bus.I_DestIdx    = d;
    bus.I_DestWrite  = dw;
    bus.I_IsBranch   = br;
  endtask

  task automatic wb(input logic [3:0] idx, input logic [15:0] data);
    bus.I_WriteBackEnable = 1'b1;
    bus.I_WriteBackRegIdx = idx;
    bus.I_WriteBackData   = data;
  endtask

  task automatic no_wb();
    bus.I_WriteBackEnable = 1'b0;
  endtask

  initial begin
    idle();
    // Reset for two edges.
    I_LOCK = 1'b0;
    step();
    step();
    chk("rst_outvalid", bus.O_OutValid, 0);
    chk("rst_src1", bus.O_Src1Value, 0);
    chk("rst_src2", bus.O_Src2Value, 0);
    chk("rst_err", bus.O_ScoreboardError, 0);
    chk("rst_brstall", bus.O_BranchStallSignal, 0);
    I_LOCK = 1'b1;

    // Read R3/R5 after reset.
    issue(4'd3, 1, 4'd5, 1, 4'd0, 0, 0);
    #1;
    chk("read_accept", bus.O_Accept, 1);
    chk("read_dep", bus.O_DepStallSignal, 0);
    step();
    idle();
    chk("read_valid", bus.O_OutValid, 1);
    chk("read_src1", bus.O_Src1Value, 0);
    chk("read_src2", bus.O_Src2Value, 0);
    step();
    chk("idle_valid", bus.O_OutValid, 0);

    // RAW on R2: stall until the writeback, which is bypassed.
    issue(4'd0, 0, 4'd0, 0, 4'd2, 1, 0);
    #1;
    chk("raw_wr_accept", bus.O_Accept, 1);
    step();
    issue(4'd2, 1, 4'd0, 0, 4'd0, 0, 0);
    #1;
    chk("raw_stall1", bus.O_DepStallSignal, 1);
    chk("raw_acc1", bus.O_Accept, 0);
    step();
    chk("raw_stall2", bus.O_DepStallSignal, 1);
    chk("raw_valid_stall", bus.O_OutValid, 0);
    wb(4'd2, 16'h1234);
    #1;
    chk("raw_bypass_dep", bus.O_DepStallSignal, 0);
    chk("raw_bypass_acc", bus.O_Accept, 1);
    step();
    idle();
    chk("raw_valid", bus.O_OutValid, 1);
    chk("raw_src1", bus.O_Src1Value, 16'h1234);

    // R7 saturation: three writes are in flight, so a fourth must wait for a
    // same-cycle writeback.
    for (int k = 0; k < 3; k++) begin
      issue(4'd0, 0, 4'd0, 0, 4'd7, 1, 0);
      #1;
      chk("sat_acc", bus.O_Accept, 1);
      step();
    end
    #1;
    chk("sat_full_dep", bus.O_DepStallSignal, 1);
    wb(4'd7, 16'h0001);
    #1;
    chk("sat_wb_acc", bus.O_Accept, 1);
    step();
    no_wb();
    #1;
    chk("sat_still3", bus.O_DepStallSignal, 1);
    idle();
    wb(4'd7, 16'h0002);
    step();
    wb(4'd7, 16'h0003);
    step();
    wb(4'd7, 16'h0777);
    step();
    idle();
    issue(4'd7, 1, 4'd2, 1, 4'd0, 0, 0);
    #1;
    chk("sat_drained_acc", bus.O_Accept, 1);
    step();
    idle();
    chk("sat_src1", bus.O_Src1Value, 16'h0777);
    chk("sat_src2", bus.O_Src2Value, 16'h1234);
    chk("sat_noerr", bus.O_ScoreboardError, 0);

    // R4 with two writes pending: a single writeback must not be bypassed.
    issue(4'd0, 0, 4'd0, 0, 4'd4, 1, 0);
    step();
    step();
    issue(4'd4, 1, 4'd0, 0, 4'd0, 0, 0);
    wb(4'd4, 16'h0044);
    #1;
    chk("dbl_stall_wb", bus.O_DepStallSignal, 1);
    chk("dbl_acc0", bus.O_Accept, 0);
    step();
    no_wb();
    #1;
    chk("dbl_stall_one", bus.O_DepStallSignal, 1);
    wb(4'd4, 16'h4444);
    #1;
    chk("dbl_acc", bus.O_Accept, 1);
    step();
    idle();
    chk("dbl_src1", bus.O_Src1Value, 16'h4444);

    // Branch blocks issue until it is resolved.
    issue(4'd0, 0, 4'd0, 0, 4'd0, 0, 1);
    #1;
    chk("br_acc", bus.O_Accept, 1);
    step();
    issue(4'd1, 1, 4'd0, 0, 4'd0, 0, 0);
    #1;
    chk("br_stall", bus.O_BranchStallSignal, 1);
    chk("br_blocked", bus.O_Accept, 0);
    chk("br_nodep", bus.O_DepStallSignal, 0);
    step();
    chk("br_novalid", bus.O_OutValid, 0);
    bus.I_BranchResolved = 1'b1;
    #1;
    chk("br_res_cycle_acc", bus.O_Accept, 0);
    step();
    bus.I_BranchResolved = 1'b0;
    #1;
    chk("br_cleared", bus.O_BranchStallSignal, 0);
    chk("br_after_acc", bus.O_Accept, 1);
    step();
    idle();
    chk("br_after_valid", bus.O_OutValid, 1);

    // Writeback to R9 with nothing pending raises the sticky error.
    wb(4'd9, 16'h0999);
    step();
    idle();
    chk("err_set", bus.O_ScoreboardError, 1);
    step();
    chk("err_sticky", bus.O_ScoreboardError, 1);
    issue(4'd9, 1, 4'd0, 0, 4'd0, 0, 0);
    #1;
    chk("err_cnt0_acc", bus.O_Accept, 1);
    step();
    idle();
    chk("err_r9", bus.O_Src1Value, 16'h0999);

    // Reset clears the state, and a writeback during reset is ignored.
    I_LOCK = 1'b0;
    wb(4'd9, 16'h5555);
    step();
    idle();
    chk("rst2_err", bus.O_ScoreboardError, 0);
    chk("rst2_valid", bus.O_OutValid, 0);
    chk("rst2_src1", bus.O_Src1Value, 0);
    I_LOCK = 1'b1;
    issue(4'd9, 1, 4'd7, 1, 4'd0, 0, 0);
    #1;
    chk("rst2_acc", bus.O_Accept, 1);
    step();
    idle();
    chk("rst2_r9", bus.O_Src1Value, 0);
    chk("rst2_r7", bus.O_Src2Value, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/regfile_scoreboard.md
Name: regfile_scoreboard

Overview:
- Decode-side receiver of the Writeback write-port interface (WriteBackEnable / WriteBackRegIdx / WriteBackData).
- Holds the architectural register file and a per-register pending-write scoreboard.
- Returns registered source operands for each instruction accepted at issue.
- Generates the dependency-stall and branch-stall signals consumed by Fetch.

Parameters:
- REG_WIDTH, 16, register data width.
- NUM_REGS, 16, number of architectural registers.
- IDX_WIDTH, 4, register index width (log2 NUM_REGS).
- CNT_WIDTH, 2, per-register pending-write counter width; max in-flight writes per register = 2^CNT_WIDTH-1.

Ports:
- I_CLOCK  in  1  clock; all state updates on rising edge.
- I_LOCK  in  1  synchronous active-low reset; low = reset, high = run.
- I_IssueValid  in  1  Decode presents an instruction.
- I_Src1Idx  in  IDX_WIDTH  source 1 index.
- I_Src1Used  in  1  source 1 is read.
- I_Src2Idx  in  IDX_WIDTH  source 2 index.
- I_Src2Used  in  1  source 2 is read.
- I_DestIdx  in  IDX_WIDTH  destination index.
- I_DestWrite  in  1  instruction will write I_DestIdx.
- I_IsBranch  in  1  instruction is a control transfer.
- I_BranchResolved  in  1  Memory stage resolved the outstanding branch (pulse).
- I_WriteBackEnable  in  1  write-port valid.
- I_WriteBackRegIdx  in  IDX_WIDTH  write-port index.
- I_WriteBackData  in  REG_WIDTH  write-port data.
- O_Accept  out  1  combinational; issue accepted this cycle.
- O_DepStallSignal  out  1  combinational dependency stall.
- O_BranchStallSignal  out  1  registered; branch outstanding.
- O_OutValid  out  1  registered; operands valid.
- O_Src1Value  out  REG_WIDTH  registered operand 1.
- O_Src2Value  out  REG_WIDTH  registered operand 2.
- O_ScoreboardError  out  1  sticky; write-port protocol violation.

Behaviour:
- Reset (I_LOCK low at clock edge):
  - All registers = 0; all counters = 0; branch_pending = 0.
  - O_OutValid = 0; O_Src1Value = O_Src2Value = 0; O_ScoreboardError = 0.
  - Reset mid-operation discards all in-flight state; writebacks in that cycle are ignored.
- Bypass condition per source: I_WriteBackEnable, I_WriteBackRegIdx == src index, and cnt[src] == 1.
- src_hazard: srcUsed and cnt[src] != 0 and bypass condition false.
- dest_full: I_DestWrite and cnt[dest] == max and no same-cycle writeback to dest.
- O_DepStallSignal = I_IssueValid & (src1_hazard | src2_hazard | dest_full).
- O_BranchStallSignal = branch_pending.
- O_Accept = I_IssueValid & ~O_DepStallSignal & ~branch_pending.
- Register write: when I_WriteBackEnable, reg[idx] <= data.
- Operand read on O_Accept:
  - O_SrcNValue <= I_WriteBackData when writeback targets that index in the same cycle (write-through); otherwise reg[idx].
  - O_OutValid <= 1. Latency 1 cycle.
  - Without accept: O_OutValid <= 0; value outputs hold.
  - Unused sources still load (don't-care content, deterministic per the rule above).
- Counter update per index (all indices evaluated in the same cycle):
  - inc = O_Accept & I_DestWrite & (I_DestIdx == idx).
  - dec = I_WriteBackEnable & (I_WriteBackRegIdx == idx).
  - inc & dec: unchanged. inc only: +1. dec only: -1.
  - dec with cnt == 0: counter stays 0 (no wrap), register still written, O_ScoreboardError <= 1 until reset.
- Branch:
  - O_Accept & I_IsBranch sets branch_pending; I_BranchResolved clears it.
  - Both in the same cycle cannot occur, since accept requires ~branch_pending.
  - I_BranchResolved while not pending: no effect.
- Source equal to dest of the same instruction: the read uses the pre-increment scoreboard; the instruction does not stall on itself.
- No combinational path from I_WriteBackData to any stall output; stall depends only on indices, enables and counters.

Test Plan:
- Reset then read: I_LOCK=0 two cycles, release; issue src1=R3, src2=R5 -> O_Accept=1, next cycle O_OutValid=1, both values 0.
- RAW stall and release: issue dest=R2; next cycle issue src1=R2 -> O_DepStallSignal=1 each cycle until writeback R2=0x1234. In the writeback cycle O_Accept=1 (bypass), next cycle O_Src1Value=0x1234.
- Counter saturation: three accepted writes to R7 with no writeback -> cnt=3. Fourth write to R7 -> O_DepStallSignal=1. Writeback R7 in the same cycle -> accepted, cnt stays 3.
- Double pending no bypass: two writes to R4 outstanding (cnt=2); reader of R4 with one writeback R4 in the same cycle -> still stalls; accepted only after the second writeback.
- Branch: accept I_IsBranch=1 -> O_BranchStallSignal=1 next cycle, O_Accept=0 for independent instructions. I_BranchResolved pulse -> stall drops next cycle; following issue accepted.
- Error: writeback R9 with cnt[R9]=0 -> R9 written, cnt stays 0, O_ScoreboardError=1 and sticks. Reset clears it.
